// File: rtl/sprite_pkg.sv
// sprite_pkg: shared keycodes, screen limits, motion types and the per-axis step rule.
// SPRITE_BOUNCE_EN selects bounce (hold and negate) instead of clamp-and-stop at the edges.
package sprite_pkg;
    typedef enum logic {S_STOP, S_MOVE} motion_state_t;
    typedef logic signed [4:0] vel_t;
    typedef struct packed {
        logic [9:0] pos;
        vel_t       vel;
    } axis_t;
    localparam logic [9:0] H_MAX   = 10'd639;
    localparam logic [9:0] V_MAX   = 10'd479;
    localparam logic [9:0] START_X = 10'd320;
    localparam logic [9:0] START_Y = 10'd240;
    localparam vel_t       STEP    = 5'sd2;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    // A position already past the limit (sprite grew) is pulled back to the limit first.
    function automatic axis_t axis_step(input logic [9:0] pos, input vel_t vel, input logic [9:0] lim);
        logic signed [11:0] n;
        axis_t r;
        n = $signed({2'b00, pos}) + $signed({{7{vel[4]}}, vel});
        r.pos = pos;
        r.vel = vel;
        if (pos > lim)
            r.pos = lim;
        else if (n < 0 || n > $signed({2'b00, lim})) begin
`ifdef SPRITE_BOUNCE_EN
            r.vel = -vel;
`else
            r.pos = n < 0 ? 10'd0 : lim;
            r.vel = '0;
`endif
        end else
            r.pos = n[9:0];
        return r;
    endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: 2-flop synchronizer plus rising-edge detector for the frame strobe.
// A low level must be seen after reset before any edge is reported.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic async_in,
    output logic tick
);
    logic r_s1, r_s2, r_prev, r_valid, r_armed;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            {r_s1, r_s2, r_prev, r_valid, r_armed} <= '0;
        end else begin
            r_s1    <= async_in;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_valid <= 1'b1;
            r_armed <= r_armed | (r_valid & ~r_s1);
        end
    end
    assign tick = r_s2 & ~r_prev & r_armed;
endmodule

// File: rtl/sprite_motion.sv
// sprite_motion: once per frame turns the keycode into a velocity and moves the sprite on screen.
// Edge behaviour is bounce when SPRITE_BOUNCE_EN is defined, clamp-and-stop otherwise.
module sprite_motion
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] width,
    input  logic [9:0] height,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       moving
);
    logic          w_tick;
    motion_state_t r_state, w_state_nx;
    vel_t          r_velx, r_vely, w_vx_key, w_vy_key;
    logic [9:0]    r_posx, r_posy, w_lim_x, w_lim_y;
    axis_t         w_ax, w_ay;
    logic          w_halt;

    frame_tick_sync u_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .async_in (frame_clk),
        .tick     (w_tick)
    );

    always_comb begin
        w_halt   = keycode == KEY_W || keycode == KEY_S || keycode == KEY_SPACE;
        w_vx_key = keycode == KEY_A ? -STEP : keycode == KEY_D ? STEP : w_halt ? '0 : r_velx;
        w_vy_key = keycode == KEY_W ? -STEP : keycode == KEY_S ? STEP :
                   (keycode == KEY_A || keycode == KEY_D || keycode == KEY_SPACE) ? '0 : r_vely;
        w_lim_x  = H_MAX - width;
        w_lim_y  = V_MAX - height;
        w_ax     = axis_step(r_posx, w_vx_key, w_lim_x);
        w_ay     = axis_step(r_posy, w_vy_key, w_lim_y);
        w_state_nx = r_state;
        if (w_tick)
            w_state_nx = (w_ax.vel != 0 || w_ay.vel != 0) ? S_MOVE : S_STOP;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            r_state <= S_STOP;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_posx <= START_X;
            r_posy <= START_Y;
            r_velx <= '0;
            r_vely <= '0;
        end else if (w_tick) begin
            r_posx <= w_ax.pos;
            r_posy <= w_ay.pos;
            r_velx <= w_ax.vel;
            r_vely <= w_ay.vel;
        end
    end

    assign PosX   = r_posx;
    assign PosY   = r_posy;
    assign moving = r_state == S_MOVE;
endmodule
